// File: rtl/ps2_arrow_decoder.sv
// ps2_arrow_decoder
//   Receives PS/2 keyboard frames (scan code set 2), validates start/parity/
//   stop and a mid-frame timeout, and tracks make/break of the four extended
//   arrow keys as a held-key bitmask for the car controller.
// Ports:
//   pclk        system clock
//   rst         synchronous, active-high reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   key[3:0]    held arrows: bit0 up, bit1 down, bit2 left, bit3 right
//   scan_code   last correctly received byte
//   scan_valid  one-cycle pulse, scan_code updated
//   frame_err   one-cycle pulse, frame rejected (parity, stop or timeout)
module ps2_arrow_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 130000
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_f_q, clk_f_d;
  logic          clk_f_prev_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [3:0]    key_q, key_d;
  logic [7:0]    code_q, code_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          fall, data;

  assign fall = clk_f_prev_q & ~clk_f_q;
  assign data = dat_s_q[1];

  always_ff @(posedge pclk) begin
    if (rst) begin
      clk_s_q      <= '1;
      dat_s_q      <= '1;
      clk_f_q      <= 1'b1;
      clk_f_prev_q <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      key_q        <= '0;
      code_q       <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      clk_s_q      <= {clk_s_q[0], ps2_clk};
      dat_s_q      <= {dat_s_q[0], ps2_data};
      clk_f_q      <= clk_f_d;
      clk_f_prev_q <= clk_f_q;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      key_q        <= key_d;
      code_q       <= code_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    clk_f_d    = clk_f_q;
    filt_cnt_d = filt_cnt_q;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    to_cnt_d   = '0;
    ext_d      = ext_q;
    brk_d      = brk_q;
    key_d      = key_q;
    code_d     = code_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    // Clock filter: toggle only after FILTER_LEN consecutive differing samples.
    if (clk_s_q[1] == clk_f_q) begin
      filt_cnt_d = '0;
    end else if (filt_cnt_q == FILT_LAST) begin
      clk_f_d    = ~clk_f_q;
      filt_cnt_d = '0;
    end else begin
      filt_cnt_d = filt_cnt_q + 1'b1;
    end

    // Mid-frame timeout; a timeout aborts the frame even if other
    // transitions would otherwise apply this cycle (no fall is present then).
    if (state_q != S_IDLE && !fall) begin
      if (to_cnt_q == TO_LAST) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    if (fall) begin
      unique case (state_q)
        S_IDLE: begin
          if (!data) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
        end
        S_DATA: begin
          shift_d   = {data, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = data;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (data && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
            code_d  = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Prefix decoder runs on the registered byte, so key lags scan_valid by one.
    if (valid_q) begin
      if (code_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (code_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (ext_q) begin
          case (code_q)
            8'h75:   key_d[0] = ~brk_q;
            8'h72:   key_d[1] = ~brk_q;
            8'h6B:   key_d[2] = ~brk_q;
            8'h74:   key_d[3] = ~brk_q;
            default: ;
          endcase
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end
  end

  assign key        = key_q;
  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
module tb_ps2_arrow_decoder;
  localparam int unsigned FL   = 8;
  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 20;

  logic       pclk = 1'b0;
  logic       rst, ps2_clk, ps2_data;
  logic [3:0] key;
  logic [7:0] scan_code;
  logic       scan_valid, frame_err;

  ps2_arrow_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(key), .scan_code(scan_code), .scan_valid(scan_valid), .frame_err(frame_err)
  );

  always #5 pclk = ~pclk;

  int tests = 0, fails = 0;
  int unsigned cyc = 0, last_fall = 0;
  int sv_cnt = 0, err_cnt = 0;

  always @(posedge pclk) cyc++;
  always @(negedge pclk) begin
    if (scan_valid) sv_cnt++;
    if (frame_err) err_cnt++;
  end

  // Reference model: prefix state and held keys from the byte stream.
  logic [3:0] m_key;
  bit         m_ext, m_brk;
  logic [7:0] m_code;
  logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_ext = 0; m_brk = 0;
    end else begin
      m_code = b;
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else begin
        if (m_ext)
          for (int i = 0; i < 4; i++) if (arrows[i] == b) m_key[i] = !m_brk;
        m_ext = 0; m_brk = 0;
      end
    end
  endfunction

  function automatic void model_reset();
    m_key = '0; m_ext = 0; m_brk = 0; m_code = '0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    repeat (HALF/2) @(posedge pclk);
    ps2_data = b;
    repeat (HALF/2) @(posedge pclk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    repeat (HALF) @(posedge pclk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [7:0] v;
    v = b;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
    send_bit((~^v) ^ bad);
    send_bit(1'b1);
    repeat (HALF) @(posedge pclk);
  endtask

  task automatic do_frame(input logic [7:0] b, input bit bad, input string name);
    int sv0, e0;
    sv0 = sv_cnt; e0 = err_cnt;
    send_frame(b, bad);
    repeat (3) @(negedge pclk);
    model_frame(b, !bad);
    check($sformatf("%s_valid", name), sv_cnt - sv0, bad ? 0 : 1);
    check($sformatf("%s_err", name), err_cnt - e0, bad ? 1 : 0);
    check($sformatf("%s_code", name), scan_code, m_code);
    check($sformatf("%s_key", name), key, m_key);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad;
    logic [3:0] exp_key;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [7:0] c, input bit bad, input logic [3:0] k);
    vec_t v;
    v.code = c; v.bad = bad; v.exp_key = k;
    tbl.push_back(v);
  endfunction

  initial begin
    int sv0, e0;
    bit seen;
    logic [7:0] pool [7] = '{8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0};
    logic [7:0] b;
    bit bad;
    int unsigned meas;

    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    model_reset();
    repeat (5) @(negedge pclk);
    check("rst_key", key, 0);
    check("rst_code", scan_code, 0);
    check("rst_valid", scan_valid, 0);
    check("rst_err", frame_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge pclk);

    // E0,75 with key latency checked around the scan_valid pulse
    do_frame(8'hE0, 0, "lat_e0");
    sv0 = sv_cnt;
    seen = 0;
    fork
      send_frame(8'h75, 0);
      begin
        for (int i = 0; i < int'(HALF * 2 * 12) && !seen; i++) begin
          @(negedge pclk);
          if (scan_valid) seen = 1;
        end
        check("lat_seen", seen, 1);
        if (seen) begin
          check("lat_code", scan_code, 8'h75);
          check("lat_key_n1", key, 4'b0000);
          @(negedge pclk);
          check("lat_key_n2", key, 4'b0001);
        end
      end
    join
    model_frame(8'h75, 1);
    repeat (2) @(negedge pclk);
    check("lat_pulses", sv_cnt - sv0, 1);

    // Short low glitch with data low: must not be taken as a start bit
    sv0 = sv_cnt; e0 = err_cnt;
    @(posedge pclk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(posedge pclk); ps2_clk = 1'b1;
    repeat (5) @(posedge pclk); ps2_data = 1'b1;
    repeat (30) @(negedge pclk);
    check("glitch_valid", sv_cnt - sv0, 0);
    check("glitch_err", err_cnt - e0, 0);
    check("glitch_key", key, 4'b0001);

    // Directed table (starting from key=0001)
    add(8'hE0,0,4'b0001); add(8'hF0,0,4'b0001); add(8'h75,0,4'b0000);
    add(8'hE0,0,4'b0000); add(8'h75,0,4'b0001);
    add(8'hE0,0,4'b0001); add(8'h74,0,4'b1001);
    add(8'hE0,0,4'b1001); add(8'hF0,0,4'b1001); add(8'h75,0,4'b1000);
    add(8'h75,1,4'b1000);
    add(8'hE0,0,4'b1000); add(8'h72,0,4'b1010);
    add(8'h75,0,4'b1010);
    add(8'hE0,0,4'b1010); add(8'h72,0,4'b1010);
    add(8'hE0,0,4'b1010); add(8'h6B,0,4'b1110);
    add(8'hE0,0,4'b1110); add(8'hF0,0,4'b1110); add(8'h74,0,4'b0110);
    add(8'hE0,0,4'b0110); add(8'h75,1,4'b0110); add(8'h72,0,4'b0110);
    add(8'hE0,0,4'b0110); add(8'h74,0,4'b1110);
    for (int i = 0; i < tbl.size(); i++) begin
      do_frame(tbl[i].code, tbl[i].bad, $sformatf("tbl%0d", i));
      check($sformatf("tbl%0d_keyexp", i), key, tbl[i].exp_key);
    end

    // Timeout after E0 + start + 5 data bits; ext must be cleared afterwards
    do_frame(8'hE0, 0, "to_e0");
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    meas = 0;
    for (int i = 0; i < int'(TO + 100) && err_cnt == e0; i++) @(negedge pclk);
    meas = cyc - last_fall;
    check("to_fired", err_cnt - e0, 1);
    check("to_window", (meas >= TO && meas <= TO + 20) ? 1 : 0, 1);
    model_frame(8'h00, 0);
    do_frame(8'h75, 0, "to_noext");
    do_frame(8'hE0, 0, "to_e0b");
    do_frame(8'h6B, 0, "to_left");

    // Randomized frames against the model
    for (int n = 0; n < 50; n++) begin
      b = ($urandom_range(0, 9) < 7) ? pool[$urandom_range(0, 6)] : 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 7) == 0);
      do_frame(b, bad, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of a frame
    do_frame(8'hE0, 0, "mr_e0");
    do_frame(8'h75, 0, "mr_up");
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    @(negedge pclk); rst = 1'b1;
    @(negedge pclk);
    check("mr_key", key, 0);
    check("mr_code", scan_code, 0);
    check("mr_valid", scan_valid, 0);
    check("mr_err", frame_err, 0);
    rst = 1'b0; ps2_data = 1'b1;
    model_reset();
    repeat (5) @(negedge pclk);
    do_frame(8'hE0, 0, "mr_post_e0");
    do_frame(8'h74, 0, "mr_post_right");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_arrow_decoder.md
Name: ps2_arrow_decoder

Overview:
- Upstream feeder of the car controller.
- Receives PS/2 keyboard frames (scan code set 2), validates them, and tracks make/break of the four extended arrow keys.
- Presents the held-key state as the 4-bit `key` bitmask that the car controller consumes on the pclk domain.
- Also exposes raw decoded bytes and an error pulse for debug.

Parameters:
- FILTER_LEN, 8: consecutive identical pclk samples required before the filtered ps2_clk level changes.
- TIMEOUT_CYCLES, 130000: pclk cycles without a ps2_clk falling edge mid-frame before the frame is aborted (about 2 ms at 65 MHz).

Ports:
- pclk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw PS/2 clock, asynchronous
- ps2_data  in  1  raw PS/2 data, asynchronous
- key  out  4  held arrow mask: bit0 up, bit1 down, bit2 left, bit3 right (registered)
- scan_code  out  8  last correctly received byte (registered)
- scan_valid  out  1  one-cycle pulse: scan_code updated
- frame_err  out  1  one-cycle pulse: frame rejected (parity, stop or timeout)

Behaviour:
- Reset is synchronous on rst, active-high, clocked by pclk.
  - Reset values: key=0, scan_code=0, scan_valid=0, frame_err=0, FSM=IDLE, ext=0, brk=0, filter and timeout counters=0.
  - Reset mid-frame discards the partial frame.
- Synchronisation: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Clock filter:
  - The filtered clock starts at 1 after reset.
  - It changes only after FILTER_LEN consecutive samples that differ from its current value.
  - The sample counter resets on any sample that equals the current value.
  - Pulses shorter than FILTER_LEN cycles are ignored.
- Edge detect: a falling edge of the filtered clock produces a one-cycle `fall` strobe. Synchronised data is sampled on `fall`.
- Frame FSM:
  - IDLE: on `fall` with data=0 (start bit), go to DATA and clear the bit counter. On `fall` with data=1, stay in IDLE with no error.
  - DATA: on each `fall`, shift data in LSB-first. After 8 bits, go to PARITY.
  - PARITY: on `fall`, store the parity bit and go to STOP.
  - STOP: on `fall`, go to IDLE.
    - The frame is good if data=1 and (8 data bits + parity) has odd parity.
    - Good frame: scan_code loaded, scan_valid=1 on the next cycle.
    - Bad frame: frame_err=1 on the next cycle; scan_code unchanged.
- Timeout:
  - The counter clears on every `fall` and runs in DATA, PARITY and STOP.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, frame_err pulses for one cycle, and ext and brk are cleared.
- Prefix decoder (acts in the cycle scan_valid=1; key updates on the following edge):
  - 0xE0: ext<=1.
  - 0xF0: brk<=1.
  - Any other byte:
    - If ext=1 and the byte is 0x75, 0x72, 0x6B or 0x74, the matching key bit (up, down, left, right) is set to !brk.
    - Then ext and brk are cleared, whether or not the byte matched.
  - Non-extended bytes never change key; e.g. keypad 0x75 without E0 is ignored.
- Bad frames clear ext and brk; key is retained.
- Latency: stop-bit `fall` at cycle N, then scan_valid at N+1, then key updated at N+2.
- Simultaneous keys: bits are independent; any combination, including opposite arrows, may be held.
- Repeated make codes (typematic) are idempotent.
- The key register is the only state the car controller sees; it changes only as described above.

Test Plan:
- E0,75 sent as valid frames -> scan_valid pulses twice with scan_code 0xE0 then 0x75; key=4'b0001 two cycles after the last stop edge.
- From key=0001, send E0,F0,75 -> key=4'b0000; no frame_err.
- Up held, then E0,74 -> key=4'b1001; then E0,F0,75 -> key=4'b1000.
- Byte 0x75 sent with even parity -> frame_err pulse; no scan_valid; key unchanged. A following valid E0,72 gives key bit1=1.
- 5 data bits, then ps2_clk held high -> frame_err exactly TIMEOUT_CYCLES after the last edge, FSM in IDLE; a subsequent full E0,6B frame decodes with key bit2=1.
- 0x75 without prefix -> scan_valid, key unchanged.
- 3-cycle low glitch on ps2_clk while idle -> no `fall`, no state change.
- rst asserted mid-frame -> all outputs 0 next cycle.
